// File: rtl/aes_byte_deserializer.sv
// Byte-to-block deserializer: packs NBYTES accepted bytes into one wide block, with a
// separate output holding register so the next block assembles while the last one waits.
module aes_byte_deserializer #(
   parameter int NBYTES    = 16,
   parameter bit MSB_FIRST = 1'b1,
   localparam int CW       = $clog2(NBYTES + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic [7:0]            in_byte,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [8*NBYTES-1:0]   out_block,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [CW-1:0]         byte_cnt
);

   logic [8*NBYTES-1:0] asm_reg;
   logic [8*NBYTES-1:0] asm_next;
   logic                accept;
   logic                last_byte;
   logic                complete;
   int                  lane_lo;

   assign last_byte = (byte_cnt == CW'(NBYTES - 1));
   // Only the completing byte can stall, and only while the holding register is full and not draining.
   assign in_ready  = rst_n & ~(last_byte & out_valid & ~out_ready);
   assign accept    = in_valid & in_ready;
   assign complete  = accept & last_byte & ~flush;

   always_comb begin
      lane_lo  = MSB_FIRST ? 8 * (NBYTES - 1 - int'(byte_cnt)) : 8 * int'(byte_cnt);
      asm_next = asm_reg;
      asm_next[lane_lo +: 8] = in_byte;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         asm_reg  <= '0;
         byte_cnt <= '0;
      end else if (flush) begin
         byte_cnt <= '0;
      end else if (accept) begin
         asm_reg  <= asm_next;
         byte_cnt <= last_byte ? '0 : byte_cnt + 1'b1;
      end
   end

   // A completing block can only arrive when the holding register is empty or draining this cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_block <= '0;
         out_valid <= 1'b0;
      end else if (complete) begin
         out_block <= asm_next;
         out_valid <= 1'b1;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_aes_byte_deserializer.sv
// Directed and randomized checks of the byte deserializer, with an MSB-first and an
// LSB-first instance sharing the same stimulus.
module tb_aes_byte_deserializer;

   logic         clk;
   logic         rst_n;
   logic         flush;
   logic [7:0]   in_byte;
   logic         in_valid;
   logic         out_ready;
   logic         in_ready_m, out_valid_m, in_ready_l, out_valid_l;
   logic [127:0] out_block_m, out_block_l;
   logic [4:0]   byte_cnt_m, byte_cnt_l;

   int checks   = 0;
   int failures = 0;

   aes_byte_deserializer #(.NBYTES(16), .MSB_FIRST(1'b1)) dut_msb (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_byte(in_byte), .in_valid(in_valid),
      .in_ready(in_ready_m), .out_block(out_block_m), .out_valid(out_valid_m),
      .out_ready(out_ready), .byte_cnt(byte_cnt_m));

   aes_byte_deserializer #(.NBYTES(16), .MSB_FIRST(1'b0)) dut_lsb (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_byte(in_byte), .in_valid(in_valid),
      .in_ready(in_ready_l), .out_block(out_block_l), .out_valid(out_valid_l),
      .out_ready(out_ready), .byte_cnt(byte_cnt_l));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_byte = 8'h00; out_ready = 1'b0;
      #3;
      checks++; if (in_ready_m !== 1'b0) begin failures++; $display("[TB] FAIL reset_in_ready got=%b exp=0", in_ready_m); end
      checks++; if (out_valid_m !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid got=%b exp=0", out_valid_m); end
      checks++; if (out_block_m !== 128'h0) begin failures++; $display("[TB] FAIL reset_out_block got=%h exp=0", out_block_m); end
      checks++; if (byte_cnt_m !== 5'd0) begin failures++; $display("[TB] FAIL reset_byte_cnt got=%0d exp=0", byte_cnt_m); end
      tick();
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (in_ready_m !== 1'b1) begin failures++; $display("[TB] FAIL idle_in_ready got=%b exp=1", in_ready_m); end
      tick();
   endtask

   task automatic test_byte_order();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int k = 0; k < 16; k++) begin
         in_byte = 8'(k);
         @(negedge clk);
         checks++; if (byte_cnt_m !== 5'(k)) begin failures++; $display("[TB] FAIL order_cnt_msb got=%0d exp=%0d", byte_cnt_m, k); end
         checks++; if (byte_cnt_l !== 5'(k)) begin failures++; $display("[TB] FAIL order_cnt_lsb got=%0d exp=%0d", byte_cnt_l, k); end
         checks++; if (out_valid_m !== 1'b0) begin failures++; $display("[TB] FAIL order_early_valid got=%b exp=0 at byte %0d", out_valid_m, k); end
         tick();
      end
      in_valid = 1'b0;
      @(negedge clk);
      checks++; if (out_valid_m !== 1'b1) begin failures++; $display("[TB] FAIL order_valid got=%b exp=1", out_valid_m); end
      checks++; if (out_block_m !== 128'h000102030405060708090A0B0C0D0E0F) begin failures++; $display("[TB] FAIL order_block_msb got=%h exp=000102030405060708090a0b0c0d0e0f", out_block_m); end
      checks++; if (out_block_l !== 128'h0F0E0D0C0B0A09080706050403020100) begin failures++; $display("[TB] FAIL order_block_lsb got=%h exp=0f0e0d0c0b0a09080706050403020100", out_block_l); end
      checks++; if (byte_cnt_m !== 5'd0) begin failures++; $display("[TB] FAIL order_cnt_wrap got=%0d exp=0", byte_cnt_m); end
      tick();
      @(negedge clk);
      checks++; if (out_valid_m !== 1'b0) begin failures++; $display("[TB] FAIL order_drain_valid got=%b exp=0", out_valid_m); end
      checks++; if (out_block_m !== 128'h000102030405060708090A0B0C0D0E0F) begin failures++; $display("[TB] FAIL order_block_kept got=%h", out_block_m); end
      tick();
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int i = 0; i < 31; i++) begin
         in_byte = 8'h20 + 8'(i);
         @(negedge clk);
         checks++; if (in_ready_m !== 1'b1) begin failures++; $display("[TB] FAIL b2b_ready got=%b exp=1 at byte %0d", in_ready_m, i); end
         tick();
      end
      in_byte = 8'h3F;
      for (int s = 0; s < 3; s++) begin
         @(negedge clk);
         checks++; if (in_ready_m !== 1'b0) begin failures++; $display("[TB] FAIL b2b_stall got=%b exp=0", in_ready_m); end
         checks++; if (out_valid_m !== 1'b1) begin failures++; $display("[TB] FAIL b2b_hold_valid got=%b exp=1", out_valid_m); end
         checks++; if (out_block_m !== 128'h202122232425262728292A2B2C2D2E2F) begin failures++; $display("[TB] FAIL b2b_hold_block got=%h exp=202122232425262728292a2b2c2d2e2f", out_block_m); end
         checks++; if (byte_cnt_m !== 5'd15) begin failures++; $display("[TB] FAIL b2b_cnt got=%0d exp=15", byte_cnt_m); end
         tick();
      end
      out_ready = 1'b1;
      @(negedge clk);
      checks++; if (in_ready_m !== 1'b1) begin failures++; $display("[TB] FAIL b2b_release got=%b exp=1", in_ready_m); end
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      checks++; if (out_valid_m !== 1'b1) begin failures++; $display("[TB] FAIL b2b_no_bubble got=%b exp=1", out_valid_m); end
      checks++; if (out_block_m !== 128'h303132333435363738393A3B3C3D3E3F) begin failures++; $display("[TB] FAIL b2b_second got=%h exp=303132333435363738393a3b3c3d3e3f", out_block_m); end
      tick();
      @(negedge clk);
      checks++; if (out_valid_m !== 1'b0) begin failures++; $display("[TB] FAIL b2b_drain got=%b exp=0", out_valid_m); end
      tick();
   endtask

   task automatic test_flush();
      int pulses;
      pulses    = 0;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_byte = 8'h50 + 8'(i);
         tick();
      end
      flush   = 1'b1;
      in_byte = 8'hEE;
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      checks++; if (byte_cnt_m !== 5'd0) begin failures++; $display("[TB] FAIL flush_cnt got=%0d exp=0", byte_cnt_m); end
      tick();
      in_valid = 1'b1;
      for (int i = 0; i < 16; i++) begin
         in_byte = 8'hA0 + 8'(i);
         @(negedge clk);
         if (out_valid_m) pulses++;
         tick();
      end
      in_valid = 1'b0;
      @(negedge clk);
      if (out_valid_m) pulses++;
      checks++; if (out_block_m !== 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF) begin failures++; $display("[TB] FAIL flush_block got=%h exp=a0a1a2a3a4a5a6a7a8a9aaabacadaeaf", out_block_m); end
      for (int s = 0; s < 2; s++) begin
         tick();
         @(negedge clk);
         if (out_valid_m) pulses++;
      end
      checks++; if (pulses !== 1) begin failures++; $display("[TB] FAIL flush_pulses got=%0d exp=1", pulses); end
      tick();
   endtask

   task automatic test_async_reset();
      int pulses;
      pulses    = 0;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int i = 0; i < 25; i++) begin
         in_byte = (i < 16) ? 8'h60 + 8'(i) : 8'h70 + 8'(i - 16);
         tick();
      end
      in_valid = 1'b0;
      @(negedge clk);
      checks++; if (out_valid_m !== 1'b1) begin failures++; $display("[TB] FAIL arst_pre_valid got=%b exp=1", out_valid_m); end
      checks++; if (byte_cnt_m !== 5'd9) begin failures++; $display("[TB] FAIL arst_pre_cnt got=%0d exp=9", byte_cnt_m); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (out_valid_m !== 1'b0) begin failures++; $display("[TB] FAIL arst_valid got=%b exp=0", out_valid_m); end
      checks++; if (out_block_m !== 128'h0) begin failures++; $display("[TB] FAIL arst_block got=%h exp=0", out_block_m); end
      checks++; if (byte_cnt_m !== 5'd0) begin failures++; $display("[TB] FAIL arst_cnt got=%0d exp=0", byte_cnt_m); end
      checks++; if (in_ready_m !== 1'b0) begin failures++; $display("[TB] FAIL arst_ready got=%b exp=0", in_ready_m); end
      tick();
      rst_n     = 1'b1;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int i = 0; i < 16; i++) begin
         in_byte = 8'h80 + 8'(i);
         @(negedge clk);
         if (out_valid_m) pulses++;
         tick();
      end
      in_valid = 1'b0;
      @(negedge clk);
      if (out_valid_m) pulses++;
      checks++; if (out_block_m !== 128'h808182838485868788898A8B8C8D8E8F) begin failures++; $display("[TB] FAIL arst_block_after got=%h exp=808182838485868788898a8b8c8d8e8f", out_block_m); end
      tick();
      @(negedge clk);
      if (out_valid_m) pulses++;
      checks++; if (pulses !== 1) begin failures++; $display("[TB] FAIL arst_pulses got=%0d exp=1", pulses); end
      tick();
   endtask

   task automatic test_random_stream();
      logic [127:0] acc;
      logic [127:0] prev_blk;
      logic [127:0] expq[$];
      int nacc, sent, recv;
      bit hold;
      acc = '0; prev_blk = '0; nacc = 0; sent = 0; recv = 0; hold = 1'b0;
      for (int cyc = 0; cyc < 60000 && recv < 1000; cyc++) begin
         in_valid  = (sent < 16000) && ($urandom_range(0, 3) != 0);
         in_byte   = 8'($urandom_range(0, 255));
         out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         if (hold) begin
            checks++;
            if (out_valid_m !== 1'b1 || out_block_m !== prev_blk) begin
               failures++;
               $display("[TB] FAIL rand_stable got=%b/%h exp=1/%h", out_valid_m, out_block_m, prev_blk);
            end
         end
         if (in_valid && in_ready_m) begin
            acc = {acc[119:0], in_byte};
            nacc++;
            sent++;
            if (nacc == 16) begin
               expq.push_back(acc);
               nacc = 0;
            end
         end
         if (out_valid_m && out_ready) begin
            checks++;
            if (expq.size() == 0) begin
               failures++;
               $display("[TB] FAIL rand_extra got=%h exp=none", out_block_m);
            end else begin
               if (out_block_m !== expq[0]) begin
                  failures++;
                  $display("[TB] FAIL rand_block got=%h exp=%h", out_block_m, expq[0]);
               end
               void'(expq.pop_front());
            end
            recv++;
         end
         hold     = out_valid_m && !out_ready;
         prev_blk = out_block_m;
         tick();
      end
      in_valid = 1'b0;
      checks++; if (recv !== 1000) begin failures++; $display("[TB] FAIL rand_count got=%0d exp=1000", recv); end
      checks++; if (expq.size() !== 0) begin failures++; $display("[TB] FAIL rand_leftover got=%0d exp=0", expq.size()); end
   endtask

   initial begin
      test_reset();
      test_byte_order();
      test_back_to_back();
      test_flush();
      test_async_reset();
      test_random_stream();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
